// File: rtl/digit_scan_pkg.sv
// Shared types for the MC14433-style digit scan multiplexer.
// Optional blanking between digits is enabled with DIGIT_SCAN_BLANK_EN.
package digit_scan_pkg;

  typedef enum logic [1:0] {S_DS1, S_DS2, S_DS3, S_DS4} scan_state_e;

  // PH_IDLE only exists between reset release and the first DS1 entry
  typedef enum logic [1:0] {PH_IDLE, PH_ACTIVE, PH_BLANK} phase_e;

  typedef struct packed {
    logic       msd;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    logic       pol;
    logic       ovr;
    logic       udr;
  } reading_t;

  localparam int Q_MSD_BIT = 3;
  localparam int Q_POL_BIT = 2;
  localparam int Q_RNG_BIT = 0;

  function automatic scan_state_e next_digit(scan_state_e s);
    case (s)
      S_DS1:   return S_DS2;
      S_DS2:   return S_DS3;
      S_DS3:   return S_DS4;
      default: return S_DS1;
    endcase
  endfunction

  // DS1 word: q3 low means a leading 1, q0 flags either range error
  function automatic logic [3:0] ds1_word(reading_t r);
    logic [3:0] w;
    w = '0;
    w[Q_MSD_BIT] = ~r.msd;
    w[Q_POL_BIT] = r.pol;
    w[Q_RNG_BIT] = r.ovr | r.udr;
    return w;
  endfunction

endpackage

// File: rtl/digit_slot_timer.sv
// Slot down-counter for the digit scan; flags the last clock of each phase.
// Blank-phase reload only exists when DIGIT_SCAN_BLANK_EN is defined.
import digit_scan_pkg::*;

module digit_slot_timer #(
  parameter int DIGIT_CYCLES = 18,
  parameter int BLANK_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  phase_e phase,
  output logic   act_end,
  output logic   blk_end
);
  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIG_LD = CW'(DIGIT_CYCLES - 1);
`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLK_LD = CW'(BLANK_CYCLES - 1);
`endif

  logic [CW-1:0] cnt;
  logic          zero;

  assign zero    = (cnt == '0);
  assign act_end = (phase == PH_ACTIVE) && zero;
  assign blk_end = (phase == PH_BLANK) && zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt <= '0;
    else if (phase == PH_IDLE || blk_end)  cnt <= DIG_LD;
`ifdef DIGIT_SCAN_BLANK_EN
    else if (act_end)                      cnt <= BLK_LD;
`else
    else if (act_end)                      cnt <= DIG_LD;
`endif
    else                                   cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Captures a 3.5-digit reading at end of conversion and scans it onto a BCD bus
// with one-hot DS1..DS4 strobes. DIGIT_SCAN_BLANK_EN adds inter-digit blanking.
import digit_scan_pkg::*;

module digit_scan_mux #(
  parameter int DIGIT_CYCLES = 18,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eoc,
  input  logic       du,
  input  logic       msd,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_t,
  input  logic [3:0] bcd_u,
  input  logic       pol,
  input  logic       ovr,
  input  logic       udr,
  output logic [3:0] ds,
  output logic [3:0] q,
  output logic       or_n
);
  scan_state_e state, nxt_state;
  phase_e      phase, nxt_phase;
  reading_t    rd_in, shadow, disp, nxt_disp;
  logic        pending, cap, enter_ds1, act_end, blk_end;
  logic [3:0]  nxt_q;

  assign rd_in = {msd, bcd_h, bcd_t, bcd_u, pol, ovr, udr};
  assign cap   = eoc & du;

  digit_slot_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .phase  (phase),
    .act_end(act_end),
    .blk_end(blk_end)
  );

  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    case (phase)
      PH_IDLE: begin
        nxt_state = S_DS1;
        nxt_phase = PH_ACTIVE;
      end
      PH_ACTIVE: if (act_end) begin
`ifdef DIGIT_SCAN_BLANK_EN
        nxt_phase = PH_BLANK;
`else
        nxt_state = next_digit(state);
`endif
      end
      PH_BLANK: if (blk_end) begin
        nxt_phase = PH_ACTIVE;
        nxt_state = next_digit(state);
      end
      default: nxt_phase = PH_IDLE;
    endcase
  end

  assign enter_ds1 = (nxt_phase == PH_ACTIVE) && (nxt_state == S_DS1) &&
                     !((phase == PH_ACTIVE) && (state == S_DS1));

  // A capture landing on the DS1 entry edge bypasses the shadow entirely
  always_comb begin
    nxt_disp = disp;
    if (enter_ds1) begin
      if (cap)          nxt_disp = rd_in;
      else if (pending) nxt_disp = shadow;
    end
  end

  always_comb begin
    nxt_q = '0;
    if (nxt_phase == PH_ACTIVE) begin
      case (nxt_state)
        S_DS1:   nxt_q = ds1_word(nxt_disp);
        S_DS2:   nxt_q = nxt_disp.h;
        S_DS3:   nxt_q = nxt_disp.t;
        default: nxt_q = nxt_disp.u;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_DS1;
      phase   <= PH_IDLE;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      ds      <= '0;
      q       <= '0;
      or_n    <= 1'b1;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      disp  <= nxt_disp;
      if (enter_ds1) begin
        pending <= 1'b0;
      end else if (cap) begin
        shadow  <= rd_in;
        pending <= 1'b1;
      end
      ds   <= (nxt_phase == PH_ACTIVE) ? (4'b0001 << nxt_state) : 4'b0000;
      q    <= nxt_q;
      or_n <= ~nxt_disp.ovr;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux: frame timing, capture/transfer, reset.
// Expected frame geometry follows DIGIT_SCAN_BLANK_EN.
import digit_scan_pkg::*;

module tb_digit_scan_mux;
  localparam int D = 18;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int SLOT  = D + B;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0, rst_n = 1'b0, eoc = 1'b0, du = 1'b0;
  reading_t   in_r = '0;
  logic [3:0] ds, q;
  logic       or_n;

  int checks = 0, errors = 0, k = -1;
  reading_t mdisp = '0, mshadow = '0;
  logic     mpend = 1'b0;

  digit_scan_mux #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .eoc(eoc), .du(du),
    .msd(in_r.msd), .bcd_h(in_r.h), .bcd_t(in_r.t), .bcd_u(in_r.u),
    .pol(in_r.pol), .ovr(in_r.ovr), .udr(in_r.udr),
    .ds(ds), .q(q), .or_n(or_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got %b want %b", tag, k, act, exp);
    end
  endtask

  function automatic reading_t mk(logic m, logic [3:0] h, logic [3:0] t, logic [3:0] u,
                                  logic p, logic o, logic ud);
    reading_t r;
    r.msd = m; r.h = h; r.t = t; r.u = u; r.pol = p; r.ovr = o; r.udr = ud;
    return r;
  endfunction

  // One clock: update the reference display, then check every output
  task automatic tick();
    logic       c, o;
    reading_t   r;
    int         p, slot, off;
    logic [3:0] eds, eq;
    c = eoc & du;
    r = in_r;
    @(posedge clk); #1;
    k++;
    p = k % FRAME;
    if (p == 0) begin
      if (c)          begin mdisp = r;       mpend = 1'b0; end
      else if (mpend) begin mdisp = mshadow; mpend = 1'b0; end
    end else if (c) begin
      mshadow = r; mpend = 1'b1;
    end
    slot = p / SLOT;
    off  = p % SLOT;
    eds = 4'b0000;
    eq  = 4'b0000;
    if (off < D) begin
      case (slot)
        0: begin eds = 4'b0001; eq = {~mdisp.msd, mdisp.pol, 1'b0, mdisp.ovr | mdisp.udr}; end
        1: begin eds = 4'b0010; eq = mdisp.h; end
        2: begin eds = 4'b0100; eq = mdisp.t; end
        default: begin eds = 4'b1000; eq = mdisp.u; end
      endcase
    end
    chk("ds", ds, eds);
    chk("q", q, eq);
    chk("or_n", {3'b000, or_n}, {3'b000, ~mdisp.ovr});
  endtask

  task automatic wait_to(input int p);
    do tick(); while ((k % FRAME) != p);
  endtask

  task automatic pulse(input reading_t r, input logic d);
    in_r = r; du = d; eoc = 1'b1;
    tick();
    eoc = 1'b0; du = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ds", ds, 4'b0000);
    chk("rst_q", q, 4'b0000);
    chk("rst_or_n", {3'b000, or_n}, 4'b0001);
    @(posedge clk); #3 rst_n = 1'b1;

    // idle frame with an empty display
    tick();
    chk("first_ds", ds, 4'b0001);
    chk("first_q", q, 4'b1000);
    wait_to(D - 1);
    chk("ds1_last", ds, 4'b0001);
    wait_to(SLOT);
    chk("ds2_start", ds, 4'b0010);
    chk("ds2_q", q, 4'b0000);
    wait_to(0);
    chk("frame_wrap", ds, 4'b0001);
    chk("frame_len", k[15:12] == 4'd0 ? 4'(k / FRAME) : 4'hf, 4'd1);

    // capture mid-DS3 appears only at the next DS1 entry
    wait_to(2 * SLOT + 4);
    pulse(mk(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0), 1'b1);
    wait_to(3 * SLOT);
    chk("cap_held_ds4", q, 4'b0000);
    wait_to(0);
    chk("cap_ds1", q, 4'b0100);
    wait_to(SLOT);
    chk("cap_ds2", q, 4'b0010);
    wait_to(2 * SLOT);
    chk("cap_ds3", q, 4'b0011);
    wait_to(3 * SLOT);
    chk("cap_ds4", q, 4'b0100);

    // eoc without du is ignored
    wait_to(5);
    pulse(mk(1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0), 1'b0);
    wait_to(0);
    wait_to(3 * SLOT);
    chk("nodu_ds4", q, 4'b0100);
    wait_to(0);
    chk("nodu_ds1", q, 4'b0100);

    // overrange raises or_n low one transfer later, then clears
    wait_to(SLOT + 2);
    pulse(mk(1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0), 1'b1);
    wait_to(FRAME - 1);
    chk("ovr_pre", {3'b000, or_n}, 4'b0001);
    wait_to(0);
    chk("ovr_or_n", {3'b000, or_n}, 4'b0000);
    chk("ovr_ds1", q, 4'b1001);
    wait_to(SLOT + 2);
    pulse(mk(1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0), 1'b1);
    wait_to(FRAME - 1);
    chk("ovr_hold", {3'b000, or_n}, 4'b0000);
    wait_to(0);
    chk("ovr_clr", {3'b000, or_n}, 4'b0001);
    chk("ovr_clr_ds1", q, 4'b1100);

    // capture on the DS1 entry edge shows in the same frame
    wait_to(FRAME - 1);
    pulse(mk(1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0), 1'b1);
    chk("coin_ds1", q, 4'b1100);
    wait_to(3 * SLOT);
    chk("coin_ds4", q, 4'b0111);

    // reset mid-DS2 with a pending reading
    wait_to(SLOT + 2);
    pulse(mk(1'b1, 4'd8, 4'd8, 4'd9, 1'b0, 1'b1, 1'b1), 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ds", ds, 4'b0000);
    chk("mid_rst_q", q, 4'b0000);
    chk("mid_rst_or_n", {3'b000, or_n}, 4'b0001);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    k = -1; mdisp = '0; mshadow = '0; mpend = 1'b0;
    tick();
    chk("post_rst_ds", ds, 4'b0001);
    chk("post_rst_q", q, 4'b1000);
    wait_to(3 * SLOT);
    chk("post_rst_ds4", q, 4'b0000);
    wait_to(0);
    chk("post_rst_ds1", q, 4'b1000);
    wait_to(SLOT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Output multiplexer stage placed directly downstream of the BCD counter chain of the MC14433 converter model. At end of conversion it captures the 3½-digit reading, polarity and range flags. It then scans them continuously onto a shared 4-bit BCD bus with one-hot digit strobes DS1..DS4, in MC14433 output order. A shadow register keeps a new reading from tearing the display mid-frame.

## Interface
Parameters:
- DIGIT_CYCLES, 18: clocks each digit strobe stays high; legal range 2..255.
- BLANK_CYCLES, 2: inter-digit blanking clocks, all strobes low; legal range 1..15; used only when the blanking macro is defined.

Ports:
- clk  in  1  conversion clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- eoc  in  1  end-of-conversion pulse, one clock wide, from the phase controller.
- du  in  1  display-update enable; a capture happens only when eoc and du are both high.
- msd  in  1  half-digit (thousands) value, 0 or 1.
- bcd_h, bcd_t, bcd_u  in  4 each  hundreds, tens and units BCD digits.
- pol  in  1  polarity; 1 = positive.
- ovr  in  1  overrange flag from the counter's G4 detect.
- udr  in  1  underrange flag.
- ds  out  4  digit strobes, one-hot or zero; ds[0]=DS1 (MSD) .. ds[3]=DS4 (LSD).
- q  out  4  multiplexed BCD or flag bus.
- or_n  out  1  overrange indicator; active-low.

## Operation
- Scan states: S_DS1 -> S_DS2 -> S_DS3 -> S_DS4 -> S_DS1, repeating forever.
- Each state has an active phase of DIGIT_CYCLES clocks, followed by a blank phase of BLANK_CYCLES clocks.
- q during each state's active phase:
  - DS1: q[3]=~msd (0 means a leading 1), q[2]=pol, q[1]=0, q[0]=ovr|udr.
  - DS2: bcd_h.
  - DS3: bcd_t.
  - DS4: bcd_u.
- Blank phase: ds=0, q=0.
- Capture: on an edge where eoc&du=1, the input set loads into the shadow register and sets pending. If eoc=1 and du=0, nothing changes.
- Transfer: on the edge entering S_DS1's active phase, if pending=1, the display register loads from shadow and pending clears.
- Capture and DS1 entry on the same edge: the display register loads the incoming inputs directly and pending stays 0.
- A second capture before transfer overwrites the shadow (last reading wins).
- Digits above 9 pass through unchecked.
- or_n = ~display.ovr; it changes only at a transfer.

## Timing
- Reset values: ds=0, q=0, or_n=1, shadow=0, display=0, pending=0, state S_DS1, slot counter 0.
- First rising edge after rst_n deasserts: ds=4'b0001, with q showing the display register (all zero, so q=4'b1000).
- ds and q are both registered and change on the same edge. There is no combinational path from input to output.
- Frame length is 4×(DIGIT_CYCLES+BLANK_CYCLES) clocks; the defaults give 80.
- Capture-to-visible latency: from 1 clock (capture on the DS1-entry edge) up to one full frame.
- Reset asserted mid-frame: everything clears immediately and asynchronously, and any pending reading is lost.
- The slot counter is $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)+1) bits wide. It reloads at every phase change.

## Configuration
- Macro: DIGIT_SCAN_BLANK_EN.
- Defined: the blank phase of BLANK_CYCLES clocks follows every active phase.
- Undefined: there is no blank phase, BLANK_CYCLES is ignored, the strobes change back-to-back, and the frame is 4×DIGIT_CYCLES clocks.

## Structure
- Package digit_scan_pkg holds:
  - the enum for the scan states;
  - a packed struct for a reading: msd, h, t, u, pol, ovr, udr;
  - localparams for the DS1 flag bit positions (Q3 half-digit, Q2 polarity, Q0 range).
- One sub-module, digit_slot_timer: the slot down-counter, which issues active/blank phase-end pulses to the scan FSM.
- The FSM, the shadow/display registers and the output mux stay in the top module.

## Test plan
- Reset, then idle with defaults: ds steps 0001 for 18 clocks, 0000 for 2, then 0010 ...; frame length 80; q=1000 during DS1 and 0000 during DS2..DS4.
- Capture msd=1, h=2, t=3, u=4, pol=1 mid-DS3: nothing changes until the next DS1 entry. The next frame shows DS1 q=0100, DS2 q=0010, DS3 q=0011, DS4 q=0100.
- eoc with du=0 carrying 1999: the display is unchanged over the next two frames.
- Capture with ovr=1: or_n goes 0 at the next DS1 entry, and DS1 q[0]=1. A later capture with ovr=0 restores or_n to 1 one frame later.
- eoc coincident with the DS1-entry edge carrying u=7: DS4 of that same frame shows 0111.
- Assert rst_n low during DS2 with pending=1: outputs go to their reset values at once. After release the display is zero and DS1 q=1000.
- Build without DIGIT_SCAN_BLANK_EN: ds never reads 0000 after the first edge, and the frame is 72 clocks.
